cpu_bus_master: RTL and testbench
=================================

CPU_BUS_MASTER -- requirements
Module: cpu_bus_master

Interface
REQ-001 Parameter WAIT_CYCLES, default 0: extra ACCESS cycles per transaction (0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command request from host.
REQ-005 cmd_ready  output  1  block can accept a command this cycle.
REQ-006 cmd_wr  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  4  target register address.
REQ-008 cmd_wdata  input  16  write data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_rdata  output  16  read data; 16'h0000 for writes.
REQ-011 address  output  4  register-file address bus.
REQ-012 data  inout  16  bidirectional data bus shared with the register-file slave.
REQ-013 cs, rd, wr  output  1 each  active-high chip select, read strobe, write strobe.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, ACCESS, HOLD, encoded in 2 bits.
REQ-015 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on an edge with cmd_valid && cmd_ready, latching cmd_wr/addr/wdata and moving IDLE->SETUP.
REQ-016 SETUP, 1 cycle: cs=1, address=latched addr, rd=wr=0; then ->ACCESS.
REQ-017 ACCESS, 1+WAIT_CYCLES cycles: cs=1; wr=1 for writes, rd=1 for reads; never both; a 4-bit down-counter SHALL time this state; then ->HOLD.
REQ-018 HOLD, 1 cycle: cs=1, rd=wr=0, address held; then ->IDLE.
REQ-019 For writes, data SHALL be driven with latched wdata in SETUP, ACCESS and HOLD; in all other cases data SHALL be 16'bz.
REQ-020 data SHALL never be driven while rd=1 or in any read transaction state.
REQ-021 For reads, rsp_rdata SHALL capture data on the rising edge that ends the last ACCESS cycle.
REQ-022 rsp_valid SHALL be 1 for exactly the HOLD cycle of every transaction; rsp_rdata SHALL hold its value until the next completion.
REQ-023 Latency: with acceptance at edge N, rsp_valid SHALL be high in cycle N+3+WAIT_CYCLES; next accept no earlier than edge N+4+WAIT_CYCLES.
REQ-024 cmd_* inputs SHALL be ignored outside IDLE; changes mid-transaction SHALL NOT affect bus outputs.
REQ-025 cmd_valid held high continuously SHALL yield back-to-back transactions with exactly one IDLE cycle between HOLD and the next SETUP.
REQ-026 address SHALL be 4'h0 whenever cs=0.

Reset
REQ-027 While reset=1, asynchronously: state=IDLE, cs=rd=wr=0, address=4'h0, data=16'bz, rsp_valid=0, rsp_rdata=16'h0000, counter=0, cmd_ready=0.
REQ-028 cmd_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Reset mid-transaction SHALL abort it: no rsp_valid for the aborted command, bus released in the same cycle reset asserts.

Verification
REQ-030 WAIT_CYCLES=0: write 16'hA5A5 to addr 3, then read addr 3 -> cs high 3 cycles per transaction, wr high 1 cycle, rsp_rdata=16'hA5A5 on the second rsp_valid.
REQ-031 WAIT_CYCLES=2: read addr 15 holding 16'h1234 -> rd high exactly 3 cycles, rsp_valid at N+5, rsp_rdata=16'h1234.
REQ-032 cmd_valid held high for 4 writes (addr 0..3, data 16'h0011..16'h0044) -> 4 rsp_valid pulses 4 cycles apart; readback matches each value.
REQ-033 Read transaction -> monitor confirms data bus driven only by the slave (master output z) in every read cycle; never rd&&wr.
REQ-034 reset asserted during ACCESS of a write -> cs/wr/rd drop and data goes z immediately; no rsp_valid; cmd_ready=1 the cycle after release.
REQ-035 cmd_addr/cmd_wdata toggled randomly during a transaction -> address and data bus remain at latched values until HOLD ends.

Source files
------------

// File: rtl/cpu_bus_master.sv
// rtl/cpu_bus_master.sv - single-outstanding register-file bus master (SETUP/ACCESS/HOLD)
// Drives a shared tri-state data bus; reads are sampled at the end of the last ACCESS cycle.
module cpu_bus_master #(
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [3:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [3:0]  address,
  inout  wire  [15:0] data,
  output logic        cs,
  output logic        rd,
  output logic        wr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  state_t      state;
  logic        wr_q;
  logic [15:0] wdata_q;
  logic [3:0]  wait_cnt;
  logic        drive_en;

  // Gated by reset so the host never sees ready while the block is held in reset.
  assign cmd_ready = (state == IDLE) && !reset;
  assign data      = drive_en ? wdata_q : 16'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      wdata_q   <= 16'h0000;
      wait_cnt  <= 4'h0;
      drive_en  <= 1'b0;
      cs        <= 1'b0;
      rd        <= 1'b0;
      wr        <= 1'b0;
      address   <= 4'h0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state    <= SETUP;
            wr_q     <= cmd_wr;
            wdata_q  <= cmd_wdata;
            address  <= cmd_addr;
            cs       <= 1'b1;
            drive_en <= cmd_wr;
          end
        end
        SETUP: begin
          state    <= ACCESS;
          wait_cnt <= WAIT_LOAD;
          rd       <= !wr_q;
          wr       <= wr_q;
        end
        ACCESS: begin
          if (wait_cnt == 4'h0) begin
            state     <= HOLD;
            rd        <= 1'b0;
            wr        <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= wr_q ? 16'h0000 : data;
          end else begin
            wait_cnt <= wait_cnt - 4'h1;
          end
        end
        HOLD: begin
          state     <= IDLE;
          cs        <= 1'b0;
          address   <= 4'h0;
          drive_en  <= 1'b0;
          rsp_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
// tb/tb_cpu_bus_master.sv - checks cpu_bus_master at WAIT_CYCLES 0 and 2 against a transaction-level model
module tb_cpu_bus_master;

  logic clk;
  logic reset;
  logic        cmd_valid [2];
  logic        cmd_wr    [2];
  logic [3:0]  cmd_addr  [2];
  logic [15:0] cmd_wdata [2];
  wire         cmd_ready_o [2];
  wire         rsp_valid_o [2];
  wire  [15:0] rsp_rdata_o [2];
  wire  [3:0]  addr_o      [2];
  wire         cs_o        [2];
  wire         rd_o        [2];
  wire         wr_o        [2];
  wire  [15:0] data0;
  wire  [15:0] data1;
  wire  [15:0] data_obs [2];

  logic [15:0] slave_mem [2][16];
  logic [15:0] ref_mem   [2][16];

  int vec_count;
  int err_count;

  cpu_bus_master #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready_o[0]), .cmd_wr(cmd_wr[0]),
    .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
    .rsp_valid(rsp_valid_o[0]), .rsp_rdata(rsp_rdata_o[0]),
    .address(addr_o[0]), .data(data0), .cs(cs_o[0]), .rd(rd_o[0]), .wr(wr_o[0])
  );

  cpu_bus_master #(.WAIT_CYCLES(2)) u_dut1 (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready_o[1]), .cmd_wr(cmd_wr[1]),
    .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
    .rsp_valid(rsp_valid_o[1]), .rsp_rdata(rsp_rdata_o[1]),
    .address(addr_o[1]), .data(data1), .cs(cs_o[1]), .rd(rd_o[1]), .wr(wr_o[1])
  );

  // Register-file slaves: drive the bus only while selected and read-strobed.
  assign data0 = (cs_o[0] && rd_o[0]) ? slave_mem[0][addr_o[0]] : 16'bz;
  assign data1 = (cs_o[1] && rd_o[1]) ? slave_mem[1][addr_o[1]] : 16'bz;
  assign data_obs[0] = data0;
  assign data_obs[1] = data1;

  always @(posedge clk) begin
    if (cs_o[0] && wr_o[0]) slave_mem[0][addr_o[0]] <= data0;
    if (cs_o[1] && wr_o[1]) slave_mem[1][addr_o[1]] <= data1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    assert (obs === exp) else begin
      err_count++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bus_vec(input int s);
    return 32'({cs_o[s], rd_o[s], wr_o[s], addr_o[s], rsp_valid_o[s], cmd_ready_o[s]});
  endfunction

  // One transaction, checked cycle by cycle against the phase schedule derived from WAIT_CYCLES.
  task automatic run_txn(input int s, input logic w, input logic [3:0] a, input logic [15:0] d);
    int guard;
    int wc;
    int last_acc;
    logic [15:0] exp_rdata;
    logic [15:0] exp_data;
    logic [15:0] zz;
    logic e_cs, e_rd, e_wr, e_rv, e_rdy, in_acc;
    logic [3:0] e_addr;
    zz = 16'bz;
    wc = (s == 0) ? 0 : 2;
    last_acc = 2 + wc;
    @(negedge clk);
    guard = 0;
    while (!cmd_ready_o[s] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_cmd", 32'(cmd_ready_o[s]), 32'd1);
    cmd_valid[s] = 1'b1;
    cmd_wr[s]    = w;
    cmd_addr[s]  = a;
    cmd_wdata[s] = d;
    @(posedge clk);
    #1;
    cmd_valid[s] = 1'b0;
    exp_rdata = w ? 16'h0000 : ref_mem[s][a];
    if (w) ref_mem[s][a] = d;
    for (int k = 1; k <= 4 + wc; k++) begin
      cmd_wr[s]    = 1'($urandom);
      cmd_addr[s]  = 4'($urandom);
      cmd_wdata[s] = 16'($urandom);
      @(negedge clk);
      in_acc = (k >= 2) && (k <= last_acc);
      e_cs   = (k <= 3 + wc);
      e_rd   = !w && in_acc;
      e_wr   = w && in_acc;
      e_addr = e_cs ? a : 4'h0;
      e_rv   = (k == 3 + wc);
      e_rdy  = (k == 4 + wc);
      if (w && e_cs)        exp_data = d;
      else if (!w && in_acc) exp_data = exp_rdata;
      else                   exp_data = zz;
      check("bus_ctrl", bus_vec(s), 32'({e_cs, e_rd, e_wr, e_addr, e_rv, e_rdy}));
      check("data_bus", 32'(data_obs[s]), 32'(exp_data));
      if (k >= 3 + wc) check("rsp_rdata", 32'(rsp_rdata_o[s]), 32'(exp_rdata));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int idx, nrsp, last, guard;
    logic acc;
    logic [15:0] zz;
    zz = 16'bz;
    vec_count = 0;
    err_count = 0;
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      cmd_valid[s] = 1'b0;
      cmd_wr[s]    = 1'b0;
      cmd_addr[s]  = 4'h0;
      cmd_wdata[s] = 16'h0000;
      for (int i = 0; i < 16; i++) begin
        ref_mem[s][i]   = 16'($urandom);
        slave_mem[s][i] = ref_mem[s][i];
      end
    end

    #1;
    for (int s = 0; s < 2; s++) begin
      check("reset_ctrl", bus_vec(s), 32'd0);
      check("reset_data", 32'(data_obs[s]), 32'(zz));
      check("reset_rdata", 32'(rsp_rdata_o[s]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_reset0", 32'(cmd_ready_o[0]), 32'd1);
    check("ready_after_reset1", 32'(cmd_ready_o[1]), 32'd1);

    // Write then read back at zero wait states.
    run_txn(0, 1'b1, 4'h3, 16'hA5A5);
    run_txn(0, 1'b0, 4'h3, 16'h0000);
    // Two wait states, read of address 15.
    run_txn(1, 1'b1, 4'hF, 16'h1234);
    run_txn(1, 1'b0, 4'hF, 16'h0000);

    // Continuous cmd_valid: four writes, expect one response every 4 cycles.
    @(negedge clk);
    idx = 0;
    nrsp = 0;
    last = 0;
    cmd_valid[0] = 1'b1;
    cmd_wr[0]    = 1'b1;
    cmd_addr[0]  = 4'h0;
    cmd_wdata[0] = 16'h0011;
    guard = 0;
    while ((idx < 4 || nrsp < 4) && guard < 40) begin
      if (rsp_valid_o[0]) begin
        if (nrsp > 0) check("b2b_gap", 32'(guard - last), 32'd4);
        last = guard;
        nrsp++;
      end
      acc = cmd_ready_o[0] && cmd_valid[0];
      @(posedge clk);
      #1;
      if (acc) begin
        ref_mem[0][idx] = 16'(16'h0011 * (idx + 1));
        idx++;
        if (idx == 4) cmd_valid[0] = 1'b0;
        else begin
          cmd_addr[0]  = 4'(idx);
          cmd_wdata[0] = 16'(16'h0011 * (idx + 1));
        end
      end
      @(negedge clk);
      guard++;
    end
    cmd_valid[0] = 1'b0;
    check("b2b_rsp_count", 32'(nrsp), 32'd4);
    for (int i = 0; i < 4; i++) run_txn(0, 1'b0, 4'(i), 16'h0000);

    // Reset during the first ACCESS cycle of a write on the wait-state instance.
    @(negedge clk);
    cmd_valid[1] = 1'b1;
    cmd_wr[1]    = 1'b1;
    cmd_addr[1]  = 4'h7;
    cmd_wdata[1] = 16'hBEEF;
    @(posedge clk);
    #1;
    cmd_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    check("pre_abort_wr", 32'({cs_o[1], wr_o[1]}), 32'b11);
    reset = 1'b1;
    #1;
    check("abort_ctrl", bus_vec(1), 32'd0);
    check("abort_data", 32'(data_obs[1]), 32'(zz));
    check("abort_rdata", 32'(rsp_rdata_o[1]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ready_after_abort", 32'(cmd_ready_o[1]), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no_rsp_after_abort", 32'({rsp_valid_o[1], cs_o[1]}), 32'd0);
    end
    check("ready_idle_after_abort", 32'(cmd_ready_o[1]), 32'd1);

    // Randomized traffic on both instances.
    for (int i = 0; i < 24; i++) begin
      run_txn(int'($urandom_range(0, 1)), 1'($urandom), 4'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    for (int i = 0; i < 4; i++) run_txn(1, 1'b0, 4'(i + 4), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
